// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Define CLA_FLAGS_EN to build the registered overflow/zero flags; otherwise they are tied to 0.

module cla_grp #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] p,
    input  logic [BLOCK-1:0] g,
    input  logic             ci,
    output logic [BLOCK-1:0] s
);
    logic cr;

    always_comb begin
        s  = '0;
        cr = ci;
        for (int i = 0; i < BLOCK; i++) begin
            s[i] = p[i] ^ g[i] ^ cr;   // p^g == a^b'
            cr   = g[i] | (p[i] & cr);
        end
    end
endmodule

module cla_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);
    localparam int NG = WIDTH / BLOCK;

    logic             s2_moves;
    logic [WIDTH-1:0] bx, p_d, g_d;
    logic [NG-1:0]    gp_d, gg_d;
    logic             gacc;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_p, s1_g;
    logic [NG-1:0]    s1_gp, s1_gg;
    logic             s1_c0;

    logic [NG:0]      gc;
    logic             acc, pall;
    logic [WIDTH-1:0] sum_d;

    assign s2_moves = out_ready | ~out_valid;
    assign in_ready = ~s1_valid | s2_moves;

    // S1: bit and group generate/propagate
    assign bx  = sub ? ~b : b;
    assign p_d = a | bx;
    assign g_d = a & bx;

    always_comb begin
        gp_d = '0;
        gg_d = '0;
        gacc = 1'b0;
        for (int k = 0; k < NG; k++) begin
            gp_d[k] = &p_d[k*BLOCK +: BLOCK];
            gacc    = 1'b0;
            for (int i = 0; i < BLOCK; i++)
                gacc = g_d[k*BLOCK+i] | (p_d[k*BLOCK+i] & gacc);
            gg_d[k] = gacc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_g     <= '0;
            s1_gp    <= '0;
            s1_gg    <= '0;
            s1_c0    <= 1'b0;
        end else begin
            if (in_ready)
                s1_valid <= in_valid;
            if (in_valid & in_ready) begin
                s1_p  <= p_d;
                s1_g  <= g_d;
                s1_gp <= gp_d;
                s1_gg <= gg_d;
                s1_c0 <= sub | cin;
            end
        end
    end

    // S2: flat lookahead over groups, gc[k] = carry into group k, gc[NG] = cout
    always_comb begin
        gc   = '0;
        acc  = 1'b0;
        pall = 1'b1;
        for (int k = 0; k <= NG; k++) begin
            acc  = 1'b0;
            pall = 1'b1;
            for (int j = k - 1; j >= 0; j--) begin
                acc  = acc | (s1_gg[j] & pall);
                pall = pall & s1_gp[j];
            end
            gc[k] = acc | (s1_c0 & pall);
        end
    end

    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla_grp #(.BLOCK(BLOCK)) u_grp (
            .p  (s1_p[k*BLOCK +: BLOCK]),
            .g  (s1_g[k*BLOCK +: BLOCK]),
            .ci (gc[k]),
            .s  (sum_d[k*BLOCK +: BLOCK])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            if (s2_moves)
                out_valid <= s1_valid;
            if (s2_moves & s1_valid) begin
                sum  <= sum_d;
                cout <= gc[NG];
            end
        end
    end

`ifdef CLA_FLAGS_EN
    // carry into the MSB is recovered from its sum bit: c = s ^ a ^ b'
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (s2_moves & s1_valid) begin
            overflow <= sum_d[WIDTH-1] ^ s1_p[WIDTH-1] ^ s1_g[WIDTH-1] ^ gc[NG];
            zero     <= ~|sum_d;
        end
    end
`else
    assign overflow = 1'b0;
    assign zero     = 1'b0;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: driver pushes expected results, monitor pops on output handshake.

module tb_cla_pipe_adder;
    localparam int W = 32;
`ifdef CLA_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        logic         z;
    } exp_t;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         in_valid = 1'b0, in_ready;
    logic [W-1:0] a = '0, b = '0, sum;
    logic         cin = 1'b0, sub = 1'b0;
    logic         out_valid, out_ready = 1'b0;
    logic         cout, overflow, zero;

    exp_t q[$];
    int   checks = 0, failures = 0;
    bit   rnd_ready = 1'b0, force_ready = 1'b0;

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(W), .BLOCK(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .overflow(overflow), .zero(zero)
    );

    // Reference: plain integer arithmetic on 64-bit values
    function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y, logic ci, logic sb);
        exp_t   e;
        longint ux, uy, sx, sy, r, sr, smax, smin;
        ux = longint'(x);
        uy = longint'(y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        smax = (longint'(1) <<< (W - 1)) - 1;
        smin = -(longint'(1) <<< (W - 1));
        if (sb) begin
            r   = ux - uy;
            sr  = sx - sy;
            e.c = (ux >= uy);
        end else begin
            r   = ux + uy + longint'(ci);
            sr  = sx + sy + longint'(ci);
            e.c = r[W];
        end
        e.s = r[W-1:0];
        e.o = FL & ((sr > smax) || (sr < smin));
        e.z = FL & (e.s == '0);
        return e;
    endfunction

    function automatic exp_t mkexp(logic [W-1:0] s, logic c, logic o, logic z);
        exp_t e;
        e.s = s;
        e.c = c;
        e.o = o & FL;
        e.z = z & FL;
        return e;
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, expv);
        end
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                        input logic sb, input exp_t e);
        @(negedge clk);
        in_valid = 1'b1; a = x; b = y; cin = ci; sub = sb;
        #1;
        for (int t = 0; t < 200 && !in_ready; t++) begin
            @(negedge clk);
            #1;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout in_ready=%b exp=1", in_ready);
        end else
            q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 400 && (q.size() != 0 || out_valid); t++) begin
            @(negedge clk);
            #3;
        end
        check("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            out_ready = rnd_ready ? ($urandom_range(3) != 0) : force_ready;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat sum=%h exp=none", sum);
                end else begin
                    e = q.pop_front();
                    if ({sum, cout, overflow, zero} !== e) begin
                        failures++;
                        $display("FAIL result got sum=%h cout=%b ovf=%b zero=%b exp sum=%h cout=%b ovf=%b zero=%b",
                                 sum, cout, overflow, zero, e.s, e.c, e.o, e.z);
                    end
                end
            end
        end
    end

    initial begin
        logic [W-1:0] ba[4], bb[4];
        logic         bc[4], bs[4];
        logic [W-1:0] x, y;
        logic         ci, sb;
        int           idx;

        repeat (2) @(negedge clk);
        #3;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_sum", 64'(sum), 64'd0);
        check("reset_cout", 64'(cout), 64'd0);
        check("reset_flags", 64'({overflow, zero}), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        force_ready = 1'b1;

        // Directed: wrap to zero, and two-edge latency
        send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, mkexp(32'h0, 1'b1, 1'b0, 1'b1));
        idle();
        #1;
        check("latency_edge1", 64'(out_valid), 64'd0);
        @(negedge clk);
        #1;
        check("latency_edge2", 64'(out_valid), 64'd1);
        send(32'h8000_0000, 32'h1, 1'b0, 1'b1, mkexp(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0));
        send(32'h3, 32'h5, 1'b1, 1'b1, mkexp(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
        send(32'h0000_0FFF, 32'h0, 1'b1, 1'b0, mkexp(32'h0000_1000, 1'b0, 1'b0, 1'b0));
        send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, mkexp(32'h8000_0000, 1'b0, 1'b1, 1'b0));
        idle();
        drain();

        // Back-pressure: only two beats fit, output holds the first result
        for (int i = 0; i < 4; i++) begin
            ba[i] = $urandom; bb[i] = $urandom; bc[i] = 1'($urandom); bs[i] = 1'($urandom);
        end
        force_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            in_valid = 1'b1; a = ba[idx]; b = bb[idx]; cin = bc[idx]; sub = bs[idx];
            #1;
            if (in_ready && idx < 4) begin
                q.push_back(model(ba[idx], bb[idx], bc[idx], bs[idx]));
                idx++;
            end
        end
        check("bp_accepted", 64'(idx), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_hold_sum", 64'(sum), 64'(q[0].s));
        force_ready = 1'b1;
        for (int i = 2; i < 4; i++)
            send(ba[i], bb[i], bc[i], bs[i], model(ba[i], bb[i], bc[i], bs[i]));
        idle();
        drain();

        // Reset with both stages full: nothing stale may come out
        force_ready = 1'b0;
        send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, model(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0));
        send(32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 1'b1, model(32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 1'b1));
        @(posedge clk);
        #3;
        in_valid = 1'b0;
        check("full_before_reset", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_sum", 64'(sum), 64'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        force_ready = 1'b1;
        repeat (5) @(negedge clk);
        #3;
        check("midrst_no_stale", 64'(out_valid), 64'd0);

        // Random stream with random back-pressure and input gaps
        rnd_ready = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            case ($urandom_range(7))
                0: x = 32'hFFFF_FFFF;
                1: x = 32'h8000_0000;
                default: x = $urandom;
            endcase
            case ($urandom_range(7))
                0: y = 32'h7FFF_FFFF;
                1: y = x;
                default: y = $urandom;
            endcase
            ci = 1'($urandom);
            sb = 1'($urandom);
            send(x, y, ci, sb, model(x, y, ci, sb));
            if ($urandom_range(7) == 0)
                idle();
        end
        idle();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
